// File: rtl/parity_pkg.sv
// Shared constants for the parity generator/checker: beat mode encodings
// and parity-sense selectors.
package parity_pkg;

  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHK = 1'b1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage : parity_pkg

// File: rtl/parity_reduce.sv
// Purely combinational XOR reduction of a W-bit vector.
module parity_reduce #(
  parameter int W = 8
) (
  input  logic [W-1:0] vec_i,
  output logic         par_o
);

  assign par_o = ^vec_i;

endmodule : parity_reduce

// File: rtl/parity_gen_chk.sv
// Streaming parity generator/checker with a single registered output stage
// and a saturating count of check-mode parity errors.
module parity_gen_chk
  import parity_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ODD    = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W:0]   out_data,
  output logic              out_err,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic             PAR_SEL = (ODD != 0) ? PAR_ODD : PAR_EVEN;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic              par_raw_s;
  logic              par_exp_s;
  logic              mismatch_s;
  logic              accept_s;
  logic              xfer_s;
  logic              err_inc_s;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W:0]   out_data_q,  out_data_d;
  logic              out_err_q,   out_err_d;
  logic [CNT_W-1:0]  err_cnt_q,   err_cnt_d;

  parity_reduce #(
    .W (DATA_W)
  ) u_reduce (
    .vec_i (in_data[DATA_W-1:0]),
    .par_o (par_raw_s)
  );

  assign par_exp_s  = par_raw_s ^ PAR_SEL;
  assign mismatch_s = in_data[DATA_W] ^ par_exp_s;

  // The stage can take a new beat whenever it is empty or being drained.
  assign in_ready  = !out_valid_q || out_ready;
  assign accept_s  = in_valid && in_ready;
  assign xfer_s    = out_valid_q && out_ready;
  assign err_inc_s = accept_s && (mode == MODE_CHK) && mismatch_s;

  // Output stage next state: load on accept, empty on a bare transfer, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      case (mode)
        MODE_GEN: begin
          out_data_d = {par_exp_s, in_data[DATA_W-1:0]};
          out_err_d  = 1'b0;
        end
        MODE_CHK: begin
          out_data_d = in_data;
          out_err_d  = mismatch_s;
        end
        default: begin
          out_data_d = in_data;
          out_err_d  = 1'b0;
        end
      endcase
    end else if (xfer_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Error counter next state: clear wins over a same-cycle increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = {CNT_W{1'b0}};
    end else if (err_inc_s && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_ONE;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State registers; reset drops any pending beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= {(DATA_W+1){1'b0}};
      out_err_q   <= 1'b0;
      err_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign err_cnt   = err_cnt_q;

endmodule : parity_gen_chk

// File: tb/tb_parity_gen_chk.sv
// Bench for parity_gen_chk: instance A uses defaults, instance B uses odd
// parity with a 2-bit counter; both see the same stimulus.
module tb_parity_gen_chk;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic        in_valid;
  logic [8:0]  in_data;
  logic        out_ready;
  logic        err_clr;

  logic        in_ready_a, out_valid_a, out_err_a;
  logic [8:0]  out_data_a;
  logic [15:0] err_cnt_a;
  logic        in_ready_b, out_valid_b, out_err_b;
  logic [8:0]  out_data_b;
  logic [1:0]  err_cnt_b;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       md;
    logic [8:0] din;
    logic [8:0] exp_data;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic [8:0] da;
    logic       ea;
    logic [8:0] db;
    logic       eb;
  } exp_t;

  exp_t        sb[$];
  logic        m_valid;
  logic [15:0] m_cnt_a;
  logic [1:0]  m_cnt_b;
  vec_t        tbl[12];
  vec_t        idle_v;
  vec_t        ok_chk_v;
  int          sat_exp[5];

  always #5 clk = ~clk;

  parity_gen_chk #(.DATA_W(8), .ODD(0), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .out_err(out_err_a), .err_clr(err_clr), .err_cnt(err_cnt_a)
  );

  parity_gen_chk #(.DATA_W(8), .ODD(1), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .out_err(out_err_b), .err_clr(err_clr), .err_cnt(err_cnt_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle, entered and left on a falling edge.
  task automatic cycle(input logic iv, input vec_t v, input logic ordy, input logic clr);
    logic exp_rdy;
    logic acc;
    exp_t e;
    in_valid  = iv;
    mode      = v.md;
    in_data   = v.din;
    out_ready = ordy;
    err_clr   = clr;
    #1;
    exp_rdy = !m_valid || ordy;
    chk("in_ready_a", 32'(in_ready_a), 32'(exp_rdy));
    chk("in_ready_b", 32'(in_ready_b), 32'(exp_rdy));
    if (m_valid && sb.size() > 0) begin
      e = sb[0];
      chk("out_data_a", 32'(out_data_a), 32'(e.da));
      chk("out_err_a",  32'(out_err_a),  32'(e.ea));
      chk("out_data_b", 32'(out_data_b), 32'(e.db));
      chk("out_err_b",  32'(out_err_b),  32'(e.eb));
      if (ordy) begin
        void'(sb.pop_front());
        m_valid = 1'b0;
      end
    end
    acc = iv && exp_rdy;
    if (acc) begin
      e.da = v.exp_data;
      e.ea = v.exp_err;
      if (v.md) begin
        e.db = v.din;
        e.eb = ~v.exp_err;
      end else begin
        e.db = {~v.exp_data[8], v.din[7:0]};
        e.eb = 1'b0;
      end
      sb.push_back(e);
      m_valid = 1'b1;
    end
    if (clr) begin
      m_cnt_a = 16'd0;
      m_cnt_b = 2'd0;
    end else if (acc && v.md) begin
      if (e.ea && m_cnt_a != 16'hFFFF) m_cnt_a = m_cnt_a + 16'd1;
      if (e.eb && m_cnt_b != 2'd3)     m_cnt_b = m_cnt_b + 2'd1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid_a", 32'(out_valid_a), 32'(m_valid));
    chk("out_valid_b", 32'(out_valid_b), 32'(m_valid));
    chk("err_cnt_a",   32'(err_cnt_a),   32'(m_cnt_a));
    chk("err_cnt_b",   32'(err_cnt_b),   32'(m_cnt_b));
  endtask

  initial begin
    tbl[0]  = '{1'b0, 9'h0EE, 9'h0EE, 1'b0};
    tbl[1]  = '{1'b0, 9'h0F8, 9'h1F8, 1'b0};
    tbl[2]  = '{1'b1, 9'h1EE, 9'h1EE, 1'b1};
    tbl[3]  = '{1'b1, 9'h0EE, 9'h0EE, 1'b0};
    tbl[4]  = '{1'b0, 9'h1EE, 9'h0EE, 1'b0};
    tbl[5]  = '{1'b1, 9'h1FF, 9'h1FF, 1'b1};
    tbl[6]  = '{1'b0, 9'h001, 9'h101, 1'b0};
    tbl[7]  = '{1'b1, 9'h17F, 9'h17F, 1'b0};
    tbl[8]  = '{1'b0, 9'h080, 9'h180, 1'b0};
    tbl[9]  = '{1'b1, 9'h007, 9'h007, 1'b1};
    tbl[10] = '{1'b0, 9'h0FF, 9'h0FF, 1'b0};
    tbl[11] = '{1'b1, 9'h0A5, 9'h0A5, 1'b0};
    idle_v   = '{1'b0, 9'h000, 9'h000, 1'b0};
    ok_chk_v = '{1'b1, 9'h0EE, 9'h0EE, 1'b0};
    sat_exp  = '{1, 2, 3, 3, 3};

    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = 9'h000;
    out_ready = 1'b0; err_clr = 1'b0;
    m_valid = 1'b0; m_cnt_a = 16'd0; m_cnt_b = 2'd0;

    #2;
    chk("rst_out_valid", 32'(out_valid_a), 32'd0);
    chk("rst_out_data",  32'(out_data_a),  32'd0);
    chk("rst_out_err",   32'(out_err_a),   32'd0);
    chk("rst_err_cnt",   32'(err_cnt_a),   32'd0);
    chk("rst_in_ready",  32'(in_ready_a),  32'd1);

    @(negedge clk);
    rst = 1'b0;

    // Back-to-back table beats with alternating modes.
    for (int i = 0; i < 12; i++) cycle(1'b1, tbl[i], 1'b1, 1'b0);
    cycle(1'b0, idle_v, 1'b1, 1'b0);

    // Check-mode error then clean beat: counter ends at one.
    cycle(1'b0, idle_v, 1'b1, 1'b1);
    cycle(1'b1, tbl[2], 1'b1, 1'b0);
    cycle(1'b1, tbl[3], 1'b1, 1'b0);
    cycle(1'b0, idle_v, 1'b1, 1'b0);
    chk("err_cnt_a_after_pair", 32'(err_cnt_a), 32'd1);

    // Backpressure: three stalled cycles with a waiting beat.
    cycle(1'b1, tbl[0], 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, tbl[1], 1'b0, 1'b0);
      chk("stall_in_ready", 32'(in_ready_a), 32'd0);
      chk("stall_out_data", 32'(out_data_a), 32'h0EE);
    end
    cycle(1'b1, tbl[1], 1'b1, 1'b0);
    cycle(1'b0, idle_v, 1'b1, 1'b0);
    chk("stall_drained", 32'(sb.size()), 32'd0);

    // Saturation of the 2-bit counter in instance B, then clear-over-increment.
    cycle(1'b0, idle_v, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, ok_chk_v, 1'b1, 1'b0);
      chk("sat_err_cnt_b", 32'(err_cnt_b), 32'(sat_exp[i]));
    end
    cycle(1'b1, ok_chk_v, 1'b1, 1'b1);
    chk("clr_priority", 32'(err_cnt_b), 32'd0);
    cycle(1'b0, idle_v, 1'b1, 1'b0);

    // Reset while a beat is stalled at the output.
    cycle(1'b1, tbl[2], 1'b0, 1'b0);
    cycle(1'b0, idle_v, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid_a), 32'd0);
    chk("midrst_err_cnt",   32'(err_cnt_a),   32'd0);
    chk("midrst_in_ready",  32'(in_ready_a),  32'd1);
    sb.delete();
    m_valid = 1'b0; m_cnt_a = 16'd0; m_cnt_b = 2'd0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, tbl[6], 1'b1, 1'b0);
    chk("post_rst_data", 32'(out_data_a), 32'h101);
    cycle(1'b0, idle_v, 1'b1, 1'b0);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_parity_gen_chk
